store_checker: RTL and testbench
================================

STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of the observed store bus.
REQ-002 SHALL have parameter DATA_W, default 32, data width of the observed store bus.
REQ-003 SHALL have parameter DEPTH, default 4, number of expected-store table entries (>=1).
REQ-004 SHALL have parameter TIMEOUT, default 1000, number of ARMED cycles before a timeout failure (>=1).
REQ-005 SHALL have parameter ORDERED, default 1; 1 means entries must match in index order, 0 means any order.
REQ-006 SHALL have parameter STRICT, default 0; 1 means a store to an address not in the table fails the check.
REQ-007 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-009 SHALL have port start, input, 1; arms the checker.
REQ-010 SHALL have port cfg_we, input, 1; table write strobe.
REQ-011 SHALL have port cfg_idx, input, $clog2(DEPTH) (min 1); table entry index.
REQ-012 SHALL have ports cfg_valid (input, 1), cfg_addr (input, ADDR_W) and cfg_data (input, DATA_W); entry contents.
REQ-013 SHALL have ports MemWrite (input, 1), DataAdr (input, ADDR_W) and WriteData (input, DATA_W); the observed store bus.
REQ-014 SHALL have ports done, pass and fail, output, 1 each; registered status.
REQ-015 SHALL have port fail_code, output, 2; 0 NONE, 1 DATA_MISMATCH, 2 UNEXPECTED, 3 TIMEOUT.
REQ-016 SHALL have port match_count, output, $clog2(DEPTH+1); number of entries matched so far.

Function
REQ-017 SHALL implement the FSM states IDLE, ARMED, PASS and FAIL.
REQ-018 SHALL output done=1 only in PASS or FAIL, pass=1 only in PASS, and fail=1 only in FAIL.
REQ-019 SHALL accept cfg_we only in IDLE, PASS or FAIL; in ARMED it is ignored; an out-of-range cfg_idx is ignored.
REQ-020 SHALL, on start=1 in any state other than ARMED, enter ARMED on the next edge and clear match_count, the hit mask, the cycle counter and fail_code; start=1 in ARMED is ignored.
REQ-021 SHALL sample the bus at each rising edge in ARMED; a store means MemWrite=1 at that edge.
REQ-022 SHALL, when ORDERED=1, compare a store only with the next un-hit valid entry, skipping entries whose valid bit is 0.
REQ-023 SHALL, when ORDERED=0, compare a store with the lowest-index valid un-hit entry whose address equals DataAdr.
REQ-024 SHALL treat an equal address with equal data as a match: mark the entry hit and increment match_count.
REQ-025 SHALL treat an equal address with different data as a failure: go to FAIL with fail_code=DATA_MISMATCH.
REQ-026 SHALL treat a store with no address match as a failure (FAIL, fail_code=UNEXPECTED) when STRICT=1, and ignore it when STRICT=0.
REQ-027 SHALL, in ORDERED mode, classify a store whose address matches a later entry but not the next one under REQ-026.
REQ-028 SHALL enter PASS on the same edge at which match_count reaches the number of valid entries, so pass is visible one cycle after the final store.
REQ-029 SHALL, if zero entries are valid, enter PASS on the first edge in ARMED.
REQ-030 SHALL increment the cycle counter every ARMED cycle and go to FAIL with fail_code=TIMEOUT when it reaches TIMEOUT-1 without completion.
REQ-031 SHALL apply priority PASS > DATA_MISMATCH/UNEXPECTED > TIMEOUT when events coincide on one edge.
REQ-032 SHALL hold PASS and FAIL, with all outputs frozen, until start or reset; bus activity in these states is ignored.

Reset
REQ-033 SHALL, while reset=0, asynchronously force state IDLE, done=pass=fail=0, fail_code=0, match_count=0, all valid bits and hit bits 0, and the cycle counter 0.
REQ-034 SHALL, on reset assertion mid-ARMED, abort the check; after release the table must be reloaded before the next start.

Structure
REQ-035 SHALL place the state enum and the fail_code enum in a package store_checker_pkg.
REQ-036 SHALL implement the expected-entry storage (valid, addr, data, hit per entry) in the sub-module store_checker_table; the FSM, comparators and counters stay in store_checker.

Verification
REQ-037 SHALL cover ordered pass: DEPTH=4, entries (96,7),(100,25) valid, stores (96,7) then (100,25) -> pass=1 one cycle after the second store, match_count=2.
REQ-038 SHALL cover data mismatch: entry (100,25), store (100,24) -> fail=1, fail_code=1 on the next cycle.
REQ-039 SHALL cover STRICT unexpected vs ignore: store (104,0) not in table -> STRICT=1 gives fail_code=2; STRICT=0 keeps ARMED with match_count unchanged.
REQ-040 SHALL cover unordered: ORDERED=0, entries (96,7),(100,25), stores (100,25) then (96,7) -> pass; the same sequence with ORDERED=1 and STRICT=1 -> fail_code=2.
REQ-041 SHALL cover timeout and coincidence: TIMEOUT=10 with no stores -> fail_code=3 after 10 ARMED cycles; the final match landing on the timeout cycle -> pass.
REQ-042 SHALL cover reset mid-ARMED: reset=0 for 3 cycles -> all outputs 0 immediately; start without reload -> pass on the first ARMED edge.

Source files
------------

// File: rtl/store_checker_pkg.sv
// store_checker_pkg
// Shared types and helpers for the store checker.
//   state_e      - checker FSM states (IDLE, ARMED, PASS, FAIL)
//   fail_code_e  - reason reported on fail_code when the check fails
//   idx_width()  - width of a table index, never narrower than one bit
package store_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE          = 2'd0,
    FC_DATA_MISMATCH = 2'd1,
    FC_UNEXPECTED    = 2'd2,
    FC_TIMEOUT       = 2'd3
  } fail_code_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_checker_table.sv
// store_checker_table
// Expected-store table: one (valid, addr, data, hit) record per entry.
// Ports:
//   i_clk, i_rst_n            - clock, asynchronous active-low reset
//   i_wr_en/idx/valid/addr/data - entry write; an index >= DEPTH is dropped
//   i_clr_hits                - clear every hit bit (new check starting)
//   i_set_hit, i_hit_idx      - mark one entry as matched
//   o_valid, o_hit            - per-entry valid and hit flags
//   o_addr, o_data            - per-entry expected address and data
module store_checker_table
  import store_checker_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_wr_en,
  input  logic [IDX_W-1:0]               i_wr_idx,
  input  logic                           i_wr_valid,
  input  logic [ADDR_W-1:0]              i_wr_addr,
  input  logic [DATA_W-1:0]              i_wr_data,
  input  logic                           i_clr_hits,
  input  logic                           i_set_hit,
  input  logic [IDX_W-1:0]               i_hit_idx,
  output logic [DEPTH-1:0]               o_valid,
  output logic [DEPTH-1:0]               o_hit,
  output logic [DEPTH-1:0][ADDR_W-1:0]   o_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]   o_data
);

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0]             r_hit;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;

  // Indices are decoded by comparing against each entry number, so an
  // out-of-range index simply selects nothing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_hit   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
          r_valid[i] <= i_wr_valid;
          r_addr[i]  <= i_wr_addr;
          r_data[i]  <= i_wr_data;
        end
        if (i_clr_hits) begin
          r_hit[i] <= 1'b0;
        end else if (i_set_hit && (i_hit_idx == IDX_W'(i))) begin
          r_hit[i] <= 1'b1;
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_hit   = r_hit;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule

// File: rtl/store_checker.sv
// store_checker
// Watches a processor store bus and checks it against a table of expected
// stores, reporting pass, data mismatch, unexpected store or timeout.
// Ports:
//   clk, reset                  - clock, asynchronous active-low reset
//   start                       - arm the checker (ignored while ARMED)
//   cfg_we/idx/valid/addr/data  - table entry write (ignored while ARMED)
//   MemWrite, DataAdr, WriteData - observed store bus
//   done, pass, fail            - registered status flags
//   fail_code                   - 0 none, 1 data mismatch, 2 unexpected, 3 timeout
//   match_count                 - entries matched in the current check
module store_checker
  import store_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000,
  parameter int ORDERED = 1,
  parameter int STRICT  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          cfg_we,
  input  logic [idx_width(DEPTH)-1:0]   cfg_idx,
  input  logic                          cfg_valid,
  input  logic [ADDR_W-1:0]             cfg_addr,
  input  logic [DATA_W-1:0]             cfg_data,
  input  logic                          MemWrite,
  input  logic [ADDR_W-1:0]             DataAdr,
  input  logic [DATA_W-1:0]             WriteData,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic [1:0]                    fail_code,
  output logic [$clog2(DEPTH+1)-1:0]    match_count
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CYC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                       r_state, w_state_next;
  fail_code_e                   r_fail_code, w_fail_code_next;
  logic [CNT_W-1:0]             r_count, w_count_next, w_count_after, w_num_valid;
  logic [CYC_W-1:0]             r_cyc, w_cyc_next;

  logic [DEPTH-1:0]             w_valid, w_hit;
  logic [DEPTH-1:0][ADDR_W-1:0] w_addr;
  logic [DEPTH-1:0][DATA_W-1:0] w_data;

  logic                         w_cand_found;
  logic [IDX_W-1:0]             w_cand_idx;
  logic [ADDR_W-1:0]            w_cand_addr;
  logic [DATA_W-1:0]            w_cand_data;
  logic                         w_configurable, w_arming, w_armed_store, w_addr_hit;
  logic                         w_store_match, w_store_mismatch, w_store_unexpected;

  assign w_configurable = (r_state != ST_ARMED);
  assign w_arming       = start && w_configurable;

  store_checker_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_wr_en    (cfg_we && w_configurable),
    .i_wr_idx   (cfg_idx),
    .i_wr_valid (cfg_valid),
    .i_wr_addr  (cfg_addr),
    .i_wr_data  (cfg_data),
    .i_clr_hits (w_arming),
    .i_set_hit  (w_store_match),
    .i_hit_idx  (w_cand_idx),
    .o_valid    (w_valid),
    .o_hit      (w_hit),
    .o_addr     (w_addr),
    .o_data     (w_data)
  );

  // Pick the entry the current store is judged against. Ordered mode takes
  // the lowest pending valid entry regardless of address, so a store to a
  // later entry's address falls through to the unexpected path. Unordered
  // mode takes the lowest pending valid entry with the same address.
  // Scanning downward lets the lowest qualifying index win.
  always_comb begin
    w_cand_found = 1'b0;
    w_cand_idx   = '0;
    w_cand_addr  = '0;
    w_cand_data  = '0;
    w_num_valid  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_num_valid = w_num_valid + CNT_W'(w_valid[i]);
      if (w_valid[i] && !w_hit[i] && ((ORDERED != 0) || (w_addr[i] == DataAdr))) begin
        w_cand_found = 1'b1;
        w_cand_idx   = IDX_W'(i);
        w_cand_addr  = w_addr[i];
        w_cand_data  = w_data[i];
      end
    end
  end

  assign w_armed_store      = (r_state == ST_ARMED) && MemWrite;
  assign w_addr_hit         = w_cand_found && (w_cand_addr == DataAdr);
  assign w_store_match      = w_armed_store && w_addr_hit && (w_cand_data == WriteData);
  assign w_store_mismatch   = w_armed_store && w_addr_hit && (w_cand_data != WriteData);
  assign w_store_unexpected = w_armed_store && !w_addr_hit;
  assign w_count_after      = w_store_match ? (r_count + CNT_W'(1)) : r_count;

  // Next-state logic. In ARMED the completion test uses the count including
  // this edge's match, which gives PASS priority over a coincident timeout.
  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_cyc_next       = r_cyc;
    w_fail_code_next = r_fail_code;
    case (r_state)
      ST_ARMED: begin
        w_count_next = w_count_after;
        if (w_count_after == w_num_valid) begin
          w_state_next = ST_PASS;
        end else if (w_store_mismatch) begin
          w_state_next     = ST_FAIL;
          w_fail_code_next = FC_DATA_MISMATCH;
        end else if (w_store_unexpected && (STRICT != 0)) begin
          w_state_next     = ST_FAIL;
          w_fail_code_next = FC_UNEXPECTED;
        end else if (r_cyc == CYC_W'(TIMEOUT - 1)) begin
          w_state_next     = ST_FAIL;
          w_fail_code_next = FC_TIMEOUT;
        end else begin
          w_cyc_next = r_cyc + CYC_W'(1);
        end
      end
      default: begin
        if (start) begin
          w_state_next     = ST_ARMED;
          w_count_next     = '0;
          w_cyc_next       = '0;
          w_fail_code_next = FC_NONE;
        end
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_cyc       <= '0;
      r_fail_code <= FC_NONE;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_cyc       <= w_cyc_next;
      r_fail_code <= w_fail_code_next;
    end
  end

  assign done        = (r_state == ST_PASS) || (r_state == ST_FAIL);
  assign pass        = (r_state == ST_PASS);
  assign fail        = (r_state == ST_FAIL);
  assign fail_code   = r_fail_code;
  assign match_count = r_count;

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker
// Drives five store_checker variants (ordered/unordered, strict/lenient,
// DEPTH 4 and 3) from one shared bus and compares each against a
// list-based model of the checking rules every cycle, plus literal
// expectations for the hand-worked scenarios.
module tb_store_checker;

  localparam int N_INST    = 5;
  localparam int TIMEOUT_P = 10;
  localparam int ORD_P [N_INST] = '{1, 1, 0, 0, 1};
  localparam int STR_P [N_INST] = '{0, 1, 0, 1, 1};
  localparam int DEP_P [N_INST] = '{4, 4, 4, 4, 3};

  typedef enum int {M_IDLE, M_ARMED, M_PASS, M_FAIL} mstate_e;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;

  logic [N_INST-1:0][7:0] dutVec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_INST; g++) begin : gInst
    localparam int D = DEP_P[g];
    logic                   oDone, oPass, oFail;
    logic [1:0]             oCode;
    logic [$clog2(D+1)-1:0] oCnt;

    store_checker #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .DEPTH   (D),
      .TIMEOUT (TIMEOUT_P),
      .ORDERED (ORD_P[g]),
      .STRICT  (STR_P[g])
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_valid   (cfg_valid),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .MemWrite    (MemWrite),
      .DataAdr     (DataAdr),
      .WriteData   (WriteData),
      .done        (oDone),
      .pass        (oPass),
      .fail        (oFail),
      .fail_code   (oCode),
      .match_count (oCnt)
    );

    assign dutVec[g] = {oDone, oPass, oFail, oCode, 3'(oCnt)};
  end

  // Reference model: table contents plus a per-instance outcome.
  mstate_e     mState [N_INST];
  bit          mValid [N_INST][4];
  bit          mHit   [N_INST][4];
  logic [31:0] mAddr  [N_INST][4];
  logic [31:0] mData  [N_INST][4];
  int          mCnt   [N_INST];
  int          mCyc   [N_INST];
  int          mCode  [N_INST];

  task automatic modelReset();
    for (int g = 0; g < N_INST; g++) begin
      mState[g] = M_IDLE;
      mCnt[g]   = 0;
      mCyc[g]   = 0;
      mCode[g]  = 0;
      for (int i = 0; i < 4; i++) begin
        mValid[g][i] = 1'b0;
        mHit[g][i]   = 1'b0;
        mAddr[g][i]  = '0;
        mData[g][i]  = '0;
      end
    end
  endtask

  task automatic modelStep(input int g);
    int  pending[$];
    int  cand;
    int  total;
    bit  mismatch;
    bit  unexpected;
    if (mState[g] != M_ARMED) begin
      if (cfg_we && (int'(cfg_idx) < DEP_P[g])) begin
        mValid[g][cfg_idx] = cfg_valid;
        mAddr[g][cfg_idx]  = cfg_addr;
        mData[g][cfg_idx]  = cfg_data;
      end
      if (start) begin
        mState[g] = M_ARMED;
        mCnt[g]   = 0;
        mCyc[g]   = 0;
        mCode[g]  = 0;
        for (int i = 0; i < 4; i++) mHit[g][i] = 1'b0;
      end
    end else begin
      total = 0;
      for (int i = 0; i < DEP_P[g]; i++) begin
        if (mValid[g][i]) begin
          total++;
          if (!mHit[g][i]) pending.push_back(i);
        end
      end
      cand       = -1;
      mismatch   = 1'b0;
      unexpected = 1'b0;
      if (MemWrite) begin
        if (ORD_P[g] != 0) begin
          if (pending.size() > 0 && mAddr[g][pending[0]] == DataAdr) cand = pending[0];
        end else begin
          foreach (pending[k]) begin
            if (cand < 0 && mAddr[g][pending[k]] == DataAdr) cand = pending[k];
          end
        end
        if (cand < 0) unexpected = 1'b1;
        else if (mData[g][cand] == WriteData) begin
          mHit[g][cand] = 1'b1;
          mCnt[g]++;
        end else mismatch = 1'b1;
      end
      if (mCnt[g] == total) mState[g] = M_PASS;
      else if (mismatch) begin
        mState[g] = M_FAIL;
        mCode[g]  = 1;
      end else if (unexpected && STR_P[g] != 0) begin
        mState[g] = M_FAIL;
        mCode[g]  = 2;
      end else if (mCyc[g] == TIMEOUT_P - 1) begin
        mState[g] = M_FAIL;
        mCode[g]  = 3;
      end else mCyc[g]++;
    end
  endtask

  function automatic logic [7:0] expVec(input int g);
    bit d, p, f;
    d = (mState[g] == M_PASS) || (mState[g] == M_FAIL);
    p = (mState[g] == M_PASS);
    f = (mState[g] == M_FAIL);
    return {d, p, f, 2'(mCode[g]), 3'(mCnt[g])};
  endfunction

  always @(negedge reset) modelReset();

  always @(posedge clk) begin
    if (!reset) modelReset();
    else for (int g = 0; g < N_INST; g++) modelStep(g);
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int g = 0; g < N_INST; g++) begin
      checks++;
      if (dutVec[g] !== expVec(g)) begin
        errors++;
        $display("[TB] FAIL model_inst%0d t=%0t actual=%b required=%b (done,pass,fail,code,cnt)",
                 g, $time, dutVec[g], expVec(g));
      end
    end
  end

  task automatic checkOutput(input string name, input int g, input bit eDone, input bit ePass,
                             input bit eFail, input int eCode, input int eCnt);
    logic [7:0] req;
    req = {eDone, ePass, eFail, 2'(eCode), 3'(eCnt)};
    checks++;
    if (dutVec[g] !== req) begin
      errors++;
      $display("[TB] FAIL %s inst%0d actual=%b required=%b (done,pass,fail,code,cnt)",
               name, g, dutVec[g], req);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit mw, input logic [31:0] adr,
                               input logic [31:0] wd);
    start     = st;
    MemWrite  = mw;
    DataAdr   = adr;
    WriteData = wd;
    @(posedge clk);
    #1;
    start    = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic cfgWrite(input int idx, input bit v, input logic [31:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_idx   = 2'(idx);
    cfg_valid = v;
    cfg_addr  = a;
    cfg_data  = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic clearTable();
    for (int i = 0; i < 4; i++) cfgWrite(i, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    modelReset();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < N_INST; g++) checkOutput("resetState", g, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Ordered pass
    clearTable();
    cfgWrite(0, 1'b1, 32'd96, 32'd7);
    cfgWrite(1, 1'b1, 32'd100, 32'd25);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
    checkOutput("armed", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 32'd96, 32'd7);
    checkOutput("ordFirst", 0, 0, 0, 0, 0, 1);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd25);
    checkOutput("ordPass", 0, 1, 1, 0, 0, 2);
    checkOutput("ordPassDep3", 4, 1, 1, 0, 0, 2);
    applyStimulus(1'b0, 1'b1, 32'd104, 32'd0);
    checkOutput("passFrozen", 0, 1, 1, 0, 0, 2);

    // Data mismatch
    cfgWrite(0, 1'b1, 32'd100, 32'd25);
    cfgWrite(1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd24);
    checkOutput("dataMismatch", 0, 1, 0, 1, 1, 0);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd25);
    checkOutput("failFrozen", 0, 1, 0, 1, 1, 0);

    // Unexpected store: strict fails, lenient ignores, then lenient times out
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd104, 32'd0);
    checkOutput("unexpStrict", 1, 1, 0, 1, 2, 0);
    checkOutput("unexpIgnore", 0, 0, 0, 0, 0, 0);
    idleCycles(9);
    checkOutput("lenientTimeout", 0, 1, 0, 1, 3, 0);

    // Out-of-order stores
    cfgWrite(0, 1'b1, 32'd96, 32'd7);
    cfgWrite(1, 1'b1, 32'd100, 32'd25);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd25);
    checkOutput("ordStrictOoo", 1, 1, 0, 1, 2, 0);
    checkOutput("unordFirst", 2, 0, 0, 0, 0, 1);
    applyStimulus(1'b0, 1'b1, 32'd96, 32'd7);
    checkOutput("unordPass", 2, 1, 1, 0, 0, 2);
    checkOutput("unordPassStrict", 3, 1, 1, 0, 0, 2);
    checkOutput("ordLenient", 0, 0, 0, 0, 0, 1);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd25);
    checkOutput("ordLenientPass", 0, 1, 1, 0, 0, 2);

    // Timeout, then final match on the timeout edge
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
    idleCycles(9);
    checkOutput("noTimeoutYet", 0, 0, 0, 0, 0, 0);
    idleCycles(1);
    checkOutput("timeout", 0, 1, 0, 1, 3, 0);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd96, 32'd7);
    idleCycles(8);
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd25);
    checkOutput("passOnTimeout", 0, 1, 1, 0, 0, 2);
    checkOutput("passOnTimeoutUnord", 2, 1, 1, 0, 0, 2);

    // Reset in the middle of a check, restart without reloading
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd96, 32'd7);
    checkOutput("preReset", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    #1;
    for (int g = 0; g < N_INST; g++) checkOutput("resetMid", g, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("noReloadPass", 0, 1, 1, 0, 0, 0);

    // Index beyond DEPTH is dropped by the three-entry instance
    clearTable();
    cfgWrite(3, 1'b1, 32'd200, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("outOfRangeDep3", 4, 1, 1, 0, 0, 0);
    checkOutput("inRangeWaiting", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 32'd200, 32'd1);
    checkOutput("inRangePass", 0, 1, 1, 0, 0, 1);

    // Randomized traffic, stores biased toward instance 0's table contents
    for (int n = 0; n < 3000; n++) begin
      int r;
      int k;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
      end else begin
        cfg_we    = (r < 22);
        cfg_idx   = 2'($urandom_range(0, 3));
        cfg_valid = ($urandom_range(0, 3) != 0);
        cfg_addr  = 32'd96 + 32'(4 * $urandom_range(0, 3));
        cfg_data  = 32'($urandom_range(0, 3));
        start     = ($urandom_range(0, 99) < 8);
        MemWrite  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
          k         = int'($urandom_range(0, 3));
          DataAdr   = mAddr[0][k];
          WriteData = mData[0][k] ^ 32'($urandom_range(0, 5) == 0);
        end else begin
          DataAdr   = 32'd96 + 32'(4 * $urandom_range(0, 3));
          WriteData = 32'($urandom_range(0, 3));
        end
        @(posedge clk);
        #1;
      end
    end
    start    = 1'b0;
    cfg_we   = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
